cache_rd_arbiter: RTL and testbench

Shares the single read channel of the AXI bridge between the instruction cache (port I) and the data cache (port D). At most one read is accepted at a time, and it stays outstanding until its last return beat. Return beats are steered back to whichever cache owns the transaction. The dcache write channel does not pass through this block; it connects to the bridge directly.

---
 rtl/cache_rd_arbiter_pkg.sv | 16 +
 rtl/cache_rd_arbiter_rr_arb2.sv | 22 ++
 rtl/cache_rd_arbiter.sv | 120 ++++++++++++
 tb/tb_cache_rd_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_rd_arbiter_pkg.sv
// rtl/cache_rd_arbiter_pkg.sv - shared encodings for the cache read-channel arbiter
package cache_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_e;

    localparam logic [2:0] RD_WORD = 3'b010;
    localparam logic [2:0] RD_LINE = 3'b100;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/cache_rd_arbiter_rr_arb2.sv
// rtl/cache_rd_arbiter_rr_arb2.sv - 2-way combinational selector with a priority input
module rr_arb2
    import cache_rd_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // req is indexed by requester ID; prio names the ID that wins a conflict.
    always_comb begin
        gnt_valid = |req;
        gnt_id    = REQ_I;
        if (req == 2'b11) begin
            gnt_id = prio;
        end else if (req[REQ_D]) begin
            gnt_id = REQ_D;
        end
    end

endmodule

// File: rtl/cache_rd_arbiter.sv
// rtl/cache_rd_arbiter.sv - shares the bridge read channel between icache and dcache
module cache_rd_arbiter
    import cache_rd_arbiter_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_rd_req,
    input  logic [2:0]  i_rd_type,
    input  logic [31:0] i_rd_addr,
    output logic        i_rd_rdy,
    output logic        i_ret_valid,
    input  logic        d_rd_req,
    input  logic [2:0]  d_rd_type,
    input  logic [31:0] d_rd_addr,
    output logic        d_rd_rdy,
    output logic        d_ret_valid,
    output logic        cache_ret_last,
    output logic [31:0] cache_ret_data,
    output logic        rd_req,
    output logic [2:0]  rd_type,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data
);

    arb_state_e state_q, state_d;
    logic       last_grant_q;
    logic       hold_valid_q;
    logic       hold_id_q;

    logic [1:0] req_vec;
    logic       prio;
    logic       arb_valid;
    logic       arb_id;
    logic       hold_live;
    logic       sel_valid;
    logic       sel_id;
    logic       accept;

    assign req_vec = {d_rd_req, i_rd_req};
    assign prio    = (ROUND_ROBIN != 0) ? ~last_grant_q : REQ_D;

    rr_arb2 u_rr_arb2 (
        .req       (req_vec),
        .prio      (prio),
        .gnt_valid (arb_valid),
        .gnt_id    (arb_id)
    );

    // A requester stalled by rd_rdy keeps the channel while it holds req high,
    // so a late request from the other side cannot swap the address mid-handshake.
    assign hold_live = hold_valid_q & req_vec[hold_id_q];
    assign sel_valid = hold_live | arb_valid;
    assign sel_id    = hold_live ? hold_id_q : arb_id;
    assign accept    = (state_q == ARB_IDLE) & sel_valid & rd_rdy;

    assign cache_ret_last = ret_last;
    assign cache_ret_data = ret_data;

    always_comb begin
        state_d     = state_q;
        rd_req      = 1'b0;
        rd_type     = 3'b000;
        rd_addr     = 32'h0;
        i_rd_rdy    = 1'b0;
        d_rd_rdy    = 1'b0;
        i_ret_valid = 1'b0;
        d_ret_valid = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                rd_req = sel_valid;
                if (sel_valid) begin
                    rd_type = (sel_id == REQ_D) ? d_rd_type : i_rd_type;
                    rd_addr = (sel_id == REQ_D) ? d_rd_addr : i_rd_addr;
                end
                i_rd_rdy = sel_valid & (sel_id == REQ_I) & rd_rdy;
                d_rd_rdy = sel_valid & (sel_id == REQ_D) & rd_rdy;
                if (accept) begin
                    state_d = (sel_id == REQ_D) ? ARB_BUSY_D : ARB_BUSY_I;
                end
            end
            ARB_BUSY_I: begin
                i_ret_valid = ret_valid;
                if (ret_valid && ret_last) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_BUSY_D: begin
                d_ret_valid = ret_valid;
                if (ret_valid && ret_last) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= REQ_I;
            hold_valid_q <= 1'b0;
            hold_id_q    <= REQ_I;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= (state_q == ARB_IDLE) & sel_valid & ~rd_rdy;
            hold_id_q    <= sel_id;
            if (accept) begin
                last_grant_q <= sel_id;
            end
        end
    end

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// tb/tb_cache_rd_arbiter.sv - self-checking bench for cache_rd_arbiter
module tb_cache_rd_arbiter;
    import cache_rd_arbiter_pkg::*;

    logic        clock;
    logic        reset;
    logic        i_rd_req, d_rd_req;
    logic [2:0]  i_rd_type, d_rd_type;
    logic [31:0] i_rd_addr, d_rd_addr;
    logic        rd_rdy, ret_valid, ret_last;
    logic [31:0] ret_data;

    // index 0: round-robin instance, index 1: fixed-priority instance
    logic        o_i_rd_rdy[2], o_d_rd_rdy[2], o_i_ret_valid[2], o_d_ret_valid[2];
    logic        o_cache_ret_last[2], o_rd_req[2];
    logic [31:0] o_cache_ret_data[2], o_rd_addr[2];
    logic [2:0]  o_rd_type[2];

    int n_checks = 0;
    int n_fail   = 0;

    cache_rd_arbiter #(.ROUND_ROBIN(1)) u_rr (
        .clock(clock), .reset(reset),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr),
        .i_rd_rdy(o_i_rd_rdy[0]), .i_ret_valid(o_i_ret_valid[0]),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr),
        .d_rd_rdy(o_d_rd_rdy[0]), .d_ret_valid(o_d_ret_valid[0]),
        .cache_ret_last(o_cache_ret_last[0]), .cache_ret_data(o_cache_ret_data[0]),
        .rd_req(o_rd_req[0]), .rd_type(o_rd_type[0]), .rd_addr(o_rd_addr[0]),
        .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data)
    );

    cache_rd_arbiter #(.ROUND_ROBIN(0)) u_fp (
        .clock(clock), .reset(reset),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr),
        .i_rd_rdy(o_i_rd_rdy[1]), .i_ret_valid(o_i_ret_valid[1]),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr),
        .d_rd_rdy(o_d_rd_rdy[1]), .d_ret_valid(o_d_ret_valid[1]),
        .cache_ret_last(o_cache_ret_last[1]), .cache_ret_data(o_cache_ret_data[1]),
        .rd_req(o_rd_req[1]), .rd_type(o_rd_type[1]), .rd_addr(o_rd_addr[1]),
        .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit rst, ir, dr, rdy, rv, rl;
        bit e_req, e_irdy, e_drdy, e_irv, e_drv;
        bit e_sel_d;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit ir, bit dr, bit rdy, bit rv, bit rl,
                                bit e_req, bit e_irdy, bit e_drdy, bit e_irv, bit e_drv,
                                bit e_sel_d);
        vec_t v;
        v.rst = rst; v.ir = ir; v.dr = dr; v.rdy = rdy; v.rv = rv; v.rl = rl;
        v.e_req = e_req; v.e_irdy = e_irdy; v.e_drdy = e_drdy;
        v.e_irv = e_irv; v.e_drv = e_drv; v.e_sel_d = e_sel_d;
        return v;
    endfunction

    // Reference model: owner/last/held use 0 = none, 1 = icache, 2 = dcache.
    int m_owner[2];
    int m_last[2];
    int m_held[2];

    function automatic int pick(int m);
        if (m_owner[m] != 0) return 0;
        if (m_held[m] == 1 && i_rd_req) return 1;
        if (m_held[m] == 2 && d_rd_req) return 2;
        if (i_rd_req && d_rd_req) return (m == 0) ? ((m_last[m] == 1) ? 2 : 1) : 2;
        if (d_rd_req) return 2;
        if (i_rd_req) return 1;
        return 0;
    endfunction

    task automatic check_model(input int m);
        int sel;
        sel = pick(m);
        chk($sformatf("m%0d rd_req", m), 32'(o_rd_req[m]), 32'(sel != 0));
        chk($sformatf("m%0d i_rd_rdy", m), 32'(o_i_rd_rdy[m]), 32'(sel == 1 && rd_rdy));
        chk($sformatf("m%0d d_rd_rdy", m), 32'(o_d_rd_rdy[m]), 32'(sel == 2 && rd_rdy));
        chk($sformatf("m%0d i_ret_valid", m), 32'(o_i_ret_valid[m]), 32'(m_owner[m] == 1 && ret_valid));
        chk($sformatf("m%0d d_ret_valid", m), 32'(o_d_ret_valid[m]), 32'(m_owner[m] == 2 && ret_valid));
        chk($sformatf("m%0d ret_data", m), o_cache_ret_data[m], ret_data);
        chk($sformatf("m%0d ret_last", m), 32'(o_cache_ret_last[m]), 32'(ret_last));
        if (sel != 0) begin
            chk($sformatf("m%0d rd_addr", m), o_rd_addr[m], (sel == 2) ? d_rd_addr : i_rd_addr);
            chk($sformatf("m%0d rd_type", m), 32'(o_rd_type[m]), 32'((sel == 2) ? d_rd_type : i_rd_type));
        end
    endtask

    task automatic update_model(input int m);
        int sel;
        sel = pick(m);
        if (reset) begin
            m_owner[m] = 0; m_last[m] = 1; m_held[m] = 0;
        end else if (m_owner[m] == 0) begin
            if (sel != 0 && rd_rdy) begin
                m_owner[m] = sel; m_last[m] = sel; m_held[m] = 0;
            end else begin
                m_held[m] = sel;
            end
        end else if (ret_valid && ret_last) begin
            m_owner[m] = 0;
        end
    endtask

    task automatic cycle_end();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        i_rd_req = 1'b0; d_rd_req = 1'b0;
        i_rd_type = RD_WORD; d_rd_type = RD_LINE;
        i_rd_addr = 32'h1C00_0000; d_rd_addr = 32'h0000_2000;
        rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = 32'h0;
        cycle_end();
        cycle_end();

        //           rst ir dr rdy rv rl  req irdy drdy irv drv  selD
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0)); // reset state
        vecs.push_back(mk(0, 1, 1, 1, 0, 0,  1, 0, 1, 0, 0,  1)); // conflict: D first
        vecs.push_back(mk(0, 1, 0, 0, 1, 0,  0, 0, 0, 0, 1,  0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0,  0, 0, 0, 0, 1,  0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0,  0, 0, 0, 0, 1,  0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1,  0, 0, 0, 0, 1,  0)); // D last beat, I locked out
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,  1, 1, 0, 0, 0,  0)); // I granted next IDLE
        vecs.push_back(mk(0, 0, 0, 0, 1, 1,  0, 0, 0, 1, 0,  0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,  1, 1, 0, 0, 0,  0)); // single I word
        vecs.push_back(mk(0, 0, 0, 0, 1, 1,  0, 0, 0, 1, 0,  0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0,  1, 0, 1, 0, 0,  1)); // alternation D
        vecs.push_back(mk(0, 1, 1, 0, 1, 1,  0, 0, 0, 0, 1,  0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0,  1, 1, 0, 0, 0,  0)); // I
        vecs.push_back(mk(0, 1, 1, 0, 1, 1,  0, 0, 0, 1, 0,  0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0,  1, 0, 1, 0, 0,  1)); // D
        vecs.push_back(mk(0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 1,  0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0,  1, 1, 0, 0, 0,  0)); // I
        vecs.push_back(mk(0, 0, 0, 0, 1, 1,  0, 0, 0, 1, 0,  0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0,  0)); // backpressure, I selected
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0, 1, 1, 0, 0, 0,  1, 0, 0, 0, 0,  0)); // D joins, I held
        vecs.push_back(mk(0, 1, 1, 1, 0, 0,  1, 1, 0, 0, 0,  0)); // I accepted
        vecs.push_back(mk(0, 0, 1, 0, 1, 1,  0, 0, 0, 1, 0,  0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,  1, 0, 1, 0, 0,  1)); // D line read
        vecs.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1,  0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1,  0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0)); // reset mid-line
        vecs.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0,  0)); // stale beats dropped
        vecs.push_back(mk(0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0,  0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0,  1, 0, 1, 0, 0,  1)); // last_grant back to I
        vecs.push_back(mk(0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 1,  0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0,  0)); // I selected, then drops
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0,  1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,  1, 0, 1, 0, 0,  1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 1,  0));

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; i_rd_req = vecs[i].ir; d_rd_req = vecs[i].dr;
            rd_rdy = vecs[i].rdy; ret_valid = vecs[i].rv; ret_last = vecs[i].rl;
            ret_data = 32'hDEAD_BEEF ^ 32'(i);
            @(negedge clock);
            chk($sformatf("v%0d rd_req", i), 32'(o_rd_req[0]), 32'(vecs[i].e_req));
            chk($sformatf("v%0d i_rd_rdy", i), 32'(o_i_rd_rdy[0]), 32'(vecs[i].e_irdy));
            chk($sformatf("v%0d d_rd_rdy", i), 32'(o_d_rd_rdy[0]), 32'(vecs[i].e_drdy));
            chk($sformatf("v%0d i_ret_valid", i), 32'(o_i_ret_valid[0]), 32'(vecs[i].e_irv));
            chk($sformatf("v%0d d_ret_valid", i), 32'(o_d_ret_valid[0]), 32'(vecs[i].e_drv));
            chk($sformatf("v%0d ret_data", i), o_cache_ret_data[0], 32'hDEAD_BEEF ^ 32'(i));
            if (vecs[i].e_req)
                chk($sformatf("v%0d rd_addr", i), o_rd_addr[0],
                    vecs[i].e_sel_d ? 32'h0000_2000 : 32'h1C00_0000);
            cycle_end();
        end

        // Fixed priority: D wins every conflict while it keeps requesting.
        reset = 1'b1; i_rd_req = 1'b0; d_rd_req = 1'b0;
        rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0;
        cycle_end();
        reset = 1'b0;
        for (int r = 0; r < 4; r++) begin
            i_rd_req = 1'b1; d_rd_req = 1'b1; rd_rdy = 1'b1; ret_valid = 1'b0; ret_last = 1'b0;
            @(negedge clock);
            chk($sformatf("fp%0d d_rd_rdy", r), 32'(o_d_rd_rdy[1]), 32'd1);
            chk($sformatf("fp%0d i_rd_rdy", r), 32'(o_i_rd_rdy[1]), 32'd0);
            cycle_end();
            rd_rdy = 1'b0; ret_valid = 1'b1; ret_last = 1'b1;
            @(negedge clock);
            chk($sformatf("fp%0d d_ret_valid", r), 32'(o_d_ret_valid[1]), 32'd1);
            cycle_end();
        end

        // Randomized traffic against the reference model, both arbitration modes.
        for (int c = 0; c < 800; c++) begin
            reset     = (c == 0) || ($urandom_range(0, 63) == 0);
            i_rd_req  = ($urandom_range(0, 2) != 0);
            d_rd_req  = ($urandom_range(0, 2) != 0);
            i_rd_type = $urandom_range(0, 1) ? RD_WORD : RD_LINE;
            d_rd_type = $urandom_range(0, 1) ? RD_WORD : RD_LINE;
            i_rd_addr = $urandom;
            d_rd_addr = $urandom;
            rd_rdy    = $urandom_range(0, 1);
            ret_valid = ($urandom_range(0, 2) != 0);
            ret_last  = ($urandom_range(0, 3) == 0);
            ret_data  = $urandom;
            @(negedge clock);
            if (c != 0) begin
                check_model(0);
                check_model(1);
            end
            update_model(0);
            update_model(1);
            cycle_end();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
